// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, tx state encoding and header packing for the router packet source
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int LEN_W    = 6;
  localparam int NUM_DEST = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } tx_state_t;

  // Header byte as the router expects it: length in the upper bits, destination in the low bits.
  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - show-ahead payload FIFO holding one full packet body
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2**LEN_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LEN_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]  rd_ptr;

  // Pointers; the FSM never writes and reads in the same state, and never exceeds 63 entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers a payload then drives header, payload and parity onto the router input
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IFG = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  output logic              start_ready,
  output logic              start_err,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              pkt_done
);

  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

  tx_state_t         state, state_n;
  logic [LEN_W:0]    cnt, cnt_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic [DATA_W-1:0] par, par_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, err_n, done_n;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W:0]    len_ext;
  logic              bad_start;

  assign len_ext     = {1'b0, len_q};
  assign bad_start   = (pay_len == '0) || (int'(dest_addr) >= NUM_DEST);
  assign start_ready = (state == S_IDLE);
  assign pl_ready    = (state == S_FILL) && (cnt < len_ext);

  router_tx_buf u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (pl_data),
    .rd_en   (rd_en),
    .rd_data (rd_data)
  );

  // State, counters, parity and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      par       <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      start_err <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      par       <= par_n;
      len_q     <= len_n;
      addr_q    <= addr_n;
      data_out  <= data_n;
      pkt_valid <= valid_n;
      start_err <= err_n;
      pkt_done  <= done_n;
    end
  end

  // Next state and next output values; cnt counts bytes stored in FILL, then bytes loaded onto data_out.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    par_n   = par;
    len_n   = len_q;
    addr_n  = addr_q;
    data_n  = '0;
    valid_n = 1'b0;
    err_n   = 1'b0;
    done_n  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (bad_start) begin
            err_n = 1'b1;
          end else begin
            len_n   = pay_len;
            addr_n  = dest_addr;
            par_n   = pack_header(pay_len, dest_addr);
            cnt_n   = '0;
            state_n = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (pl_valid && pl_ready) begin
          wr_en = 1'b1;
          par_n = par ^ pl_data;
          cnt_n = cnt + 1'b1;
        end else if (cnt == len_ext) begin
          data_n  = pack_header(len_q, addr_q);
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = S_HEADER;
        end
      end
      S_HEADER: begin
        data_n  = data_out;
        valid_n = 1'b1;
        if (!busy) begin
          data_n  = rd_data;
          rd_en   = 1'b1;
          cnt_n   = {{LEN_W{1'b0}}, 1'b1};
          state_n = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        data_n  = data_out;
        valid_n = 1'b1;
        if (!busy) begin
          if (cnt == len_ext) begin
            data_n  = par;
            valid_n = 1'b0;
            state_n = S_PARITY;
          end else begin
            data_n = rd_data;
            rd_en  = 1'b1;
            cnt_n  = cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        data_n = par;
        if (!busy) begin
          data_n  = '0;
          done_n  = 1'b1;
          gcnt_n  = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt == GW'(IFG - 1)) state_n = S_IDLE;
        else                      gcnt_n  = gcnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic       start_ready;
  logic       start_err;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       pkt_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       b;
  } beat_t;

  beat_t      tr[$];
  logic [7:0] pay[$];
  logic [7:0] got[$];
  logic       gv[$];

  router_pkt_tx #(.IFG(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .pay_len     (pay_len),
    .start_ready (start_ready),
    .start_err   (start_err),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .busy        (busy),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .pkt_done    (pkt_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
    start     = 1'b1;
    dest_addr = a;
    pay_len   = l;
    tick();
    start = 1'b0;
  endtask

  // Pushes pay[] through the payload handshake; records whether pkt_valid rose while filling.
  task automatic fill(input bit rnd, output bit saw_valid, output bit timeout);
    int  idx = 0;
    int  n   = 0;
    bit  fire;
    saw_valid = 1'b0;
    while (idx < pay.size() && n < 2000) begin
      pl_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pl_data  = pay[idx];
      fire     = pl_valid && pl_ready;
      tick();
      if (pkt_valid) saw_valid = 1'b1;
      if (fire) idx++;
      n++;
    end
    pl_valid = 1'b0;
    timeout  = (idx < pay.size());
  endtask

  // Acts as the router: records every cycle, holds busy on beat stall_idx for stall_n cycles.
  task automatic collect(input int nbeats, input int stall_idx, input int stall_n, output bit timeout);
    int    beat = 0;
    int    st   = 0;
    int    n    = 0;
    bit    b;
    beat_t e;
    tr.delete();
    got.delete();
    gv.delete();
    while (!pkt_valid && n < 200) begin
      tick();
      n++;
    end
    while (beat < nbeats && n < 2000) begin
      b = (beat == stall_idx) && (st < stall_n);
      if (b) st++;
      busy = b;
      e.d  = data_out;
      e.v  = pkt_valid;
      e.b  = b;
      tr.push_back(e);
      if (!b) begin
        got.push_back(data_out);
        gv.push_back(pkt_valid);
      end
      tick();
      if (!b) beat++;
      n++;
    end
    busy    = 1'b0;
    timeout = (beat < nbeats);
  endtask

  task automatic wait_idle(output bit timeout);
    int n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    timeout = !start_ready;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    dest_addr = '0;
    pay_len   = '0;
    pl_data   = '0;
    pl_valid  = 1'b0;
    busy      = 1'b0;
    tick();
    tick();
    checks++;
    if ({pkt_valid, data_out, pl_ready, start_err, pkt_done} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b data=%0h pl_ready=%0b err=%0b done=%0b required all 0",
               pkt_valid, data_out, pl_ready, start_err, pkt_done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_start_ready: got %0b required 1", start_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic       exp_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit saw, to1, to2, to3;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_pkt(2'd1, 6'd4);
    fill(1'b0, saw, to1);
    collect(6, -1, 0, to2);
    checks++;
    if (to1 || to2) begin
      failures++;
      $display("FAIL basic_timeout: fill=%0b collect=%0b required 0 0", to1, to2);
    end
    checks++;
    if (got.size() != 6) begin
      failures++;
      $display("FAIL basic_beats: got %0d required 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_d[i] || gv[i] !== exp_v[i]) begin
        failures++;
        $display("FAIL basic_beat%0d: got data=%0h valid=%0b required data=%0h valid=%0b",
                 i, got[i], gv[i], exp_d[i], exp_v[i]);
      end
    end
    checks++;
    if (pkt_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_pulse: got %0b required 1", pkt_done);
    end
    tick();
    checks++;
    if (pkt_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width: got %0b required 0", pkt_done);
    end
    wait_idle(to3);
  endtask

  task automatic test_busy_hold();
    logic [7:0] exp_d [6] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bit saw, to1, to2, to3;
    int held = 0;
    int held_bad = 0;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_pkt(2'd1, 6'd4);
    fill(1'b0, saw, to1);
    collect(6, 2, 3, to2);
    foreach (tr[i]) begin
      if (tr[i].d == 8'h22) begin
        held++;
        if (tr[i].v !== 1'b1) held_bad++;
      end
    end
    checks++;
    if (to1 || to2 || tr.size() != 9) begin
      failures++;
      $display("FAIL busy_trace_len: got %0d cycles (timeouts %0b %0b) required 9", tr.size(), to1, to2);
    end
    checks++;
    if (held != 4 || held_bad != 0) begin
      failures++;
      $display("FAIL busy_hold_22: got %0d cycles (%0d without valid) required 4 with valid", held, held_bad);
    end
    checks++;
    if (got.size() != 6) begin
      failures++;
      $display("FAIL busy_beats: got %0d required 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL busy_beat%0d: got %0h required %0h", i, got[i], exp_d[i]);
      end
    end
    wait_idle(to3);
  endtask

  task automatic test_long_random();
    bit saw, to1, to2, to3;
    logic [7:0] p = 8'hFE;
    int bad = 0;
    int vbad = 0;
    pay.delete();
    for (int i = 0; i < 63; i++) begin
      pay.push_back(8'(i * 5 + 3));
      p = p ^ 8'(i * 5 + 3);
    end
    start_pkt(2'd2, 6'd63);
    fill(1'b1, saw, to1);
    checks++;
    if (saw || pkt_valid !== 1'b0 || to1) begin
      failures++;
      $display("FAIL long_early_valid: got saw=%0b now=%0b timeout=%0b required 0 0 0", saw, pkt_valid, to1);
    end
    collect(65, -1, 0, to2);
    checks++;
    if (to2 || tr.size() != 65) begin
      failures++;
      $display("FAIL long_trace_len: got %0d required 65", tr.size());
    end
    for (int i = 0; i < 64 && i < tr.size(); i++) if (tr[i].v !== 1'b1) vbad++;
    checks++;
    if (vbad != 0) begin
      failures++;
      $display("FAIL long_contiguous: got %0d gaps in pkt_valid required 0", vbad);
    end
    checks++;
    if (got.size() != 65 || got[0] !== 8'hFE) begin
      failures++;
      $display("FAIL long_header: got %0h (%0d beats) required fe (65 beats)", got[0], got.size());
    end
    for (int i = 0; i < 63 && i + 1 < got.size(); i++) if (got[i+1] !== pay[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL long_payload: got %0d wrong bytes required 0", bad);
    end
    checks++;
    if (got.size() == 65 && (got[64] !== p || gv[64] !== 1'b0)) begin
      failures++;
      $display("FAIL long_parity: got %0h valid=%0b required %0h valid=0", got[64], gv[64], p);
    end
    wait_idle(to3);
  endtask

  task automatic test_bad_start();
    logic [1:0] a [2] = '{2'd0, 2'd3};
    logic [5:0] l [2] = '{6'd0, 6'd5};
    for (int k = 0; k < 2; k++) begin
      start_pkt(a[k], l[k]);
      checks++;
      if (start_err !== 1'b1 || start_ready !== 1'b1 || pkt_valid !== 1'b0) begin
        failures++;
        $display("FAIL bad_start%0d: got err=%0b ready=%0b valid=%0b required 1 1 0",
                 k, start_err, start_ready, pkt_valid);
      end
      tick();
      checks++;
      if (start_err !== 1'b0 || start_ready !== 1'b1 || pkt_valid !== 1'b0) begin
        failures++;
        $display("FAIL bad_start%0d_after: got err=%0b ready=%0b valid=%0b required 0 1 0",
                 k, start_err, start_ready, pkt_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d [4] = '{8'h0A, 8'hA5, 8'h5A, 8'hF5};
    bit saw, to1, to2, to3;
    int n = 0;
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    start_pkt(2'd0, 6'd5);
    fill(1'b0, saw, to1);
    while (!pkt_valid && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (pkt_valid !== 1'b1 || data_out !== 8'h02) begin
      failures++;
      $display("FAIL mid_payload: got valid=%0b data=%0h required 1 02", pkt_valid, data_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got valid=%0b data=%0h required 0 00", pkt_valid, data_out);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    pay = '{8'hA5, 8'h5A};
    start_pkt(2'd2, 6'd2);
    fill(1'b0, saw, to2);
    collect(4, -1, 0, to3);
    checks++;
    if (to2 || to3 || got.size() != 4) begin
      failures++;
      $display("FAIL post_reset_beats: got %0d required 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL post_reset_beat%0d: got %0h required %0h", i, got[i], exp_d[i]);
      end
    end
    wait_idle(to1);
  endtask

  task automatic test_back_to_back();
    bit saw, to1, to2, to3;
    int gap = 0;
    int gbad = 0;
    int par_cycles = 0;
    pay = '{8'h77};
    start_pkt(2'd0, 6'd1);
    fill(1'b0, saw, to1);
    collect(3, 2, 2, to2);
    foreach (tr[i]) if (tr[i].v == 1'b0) par_cycles++;
    checks++;
    if (par_cycles != 3 || got.size() != 3 || got[2] !== 8'h73) begin
      failures++;
      $display("FAIL b2b_parity_stall: got %0d parity cycles, parity %0h required 3 cycles, 73",
               par_cycles, got[2]);
    end
    while (!start_ready && gap < 20) begin
      if (pkt_valid !== 1'b0 || data_out !== 8'h00) gbad++;
      gap++;
      tick();
    end
    checks++;
    if (gap != 2 || gbad != 0) begin
      failures++;
      $display("FAIL b2b_gap: got %0d idle cycles (%0d dirty) required 2 clean", gap, gbad);
    end
    pay = '{8'h88};
    start_pkt(2'd1, 6'd1);
    fill(1'b0, saw, to3);
    collect(3, -1, 0, to2);
    checks++;
    if (got.size() != 3 || got[0] !== 8'h05 || got[1] !== 8'h88 || got[2] !== 8'h8D) begin
      failures++;
      $display("FAIL b2b_second: got %0h %0h %0h required 05 88 8d", got[0], got[1], got[2]);
    end
    wait_idle(to1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_long_random();
    test_bad_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
